k2_program_loader: RTL and testbench
====================================

Name: k2_program_loader

Overview:
- Writable instruction store for the K2 processor, replacing the fixed per-program ROM.
- Accepts a program over a byte-stream valid/ready handshake, verifies it with a trailing checksum byte, then serves instructions to the processor fetch port.
- Holds the processor in reset (cpu_hold) until a verified image is resident.
- Sits between an external host or boot source and the K2 processor's ProgramAddress/instruction_data fetch interface.

Parameters:
- ADDR_W, 4, program address width; DEPTH = 2**ADDR_W words.
- INST_W, 8, instruction word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a new load.
- load_len  in  ADDR_W+1  instruction count N; sampled only on load_start; legal range 1..DEPTH.
- load_data  in  INST_W  stream byte: N instructions in address order, then 1 checksum byte.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  loader accepts load_data this cycle.
- ProgramAddress  in  ADDR_W  processor fetch address.
- instruction_data  out  INST_W  word at ProgramAddress.
- cpu_hold  out  1  high keeps the processor in reset; drive the processor's rst_n from its inverse.
- load_done  out  1  one-cycle pulse when the checksum passes.
- load_error  out  1  level; high from a failed load until the next load_start or rst.

Behaviour:
- Storage: DEPTH x INST_W flop array.
- Read path: instruction_data = mem[ProgramAddress], combinational, zero latency, same timing as the program ROM. Valid in every state.
- Write path: memory writes only in LOAD.
- Handshake: a byte transfers on a rising clk edge where load_valid & load_ready. With load_ready high, load_data must be accepted in that cycle with no bubble. load_valid may be held high across multiple bytes.
- Running sum: 8-bit, modulo 2**INST_W, of all transferred bytes including the checksum byte. Image is good when the sum equals 0.
- FSM states: IDLE, LOAD, CHECK, RUN, ERROR.
- Reset (rst=1 at an edge), from any state including mid-load:
  - state=IDLE; all mem words=0; wr_ptr=0; sum=0.
  - load_ready=0; cpu_hold=1; load_done=0; load_error=0.
- IDLE: cpu_hold=1, load_ready=0. On load_start, go to LOAD or ERROR (see below).
- On load_start, from any state:
  - clear all mem to 0; wr_ptr=0; sum=0; load_error=0; latch N.
  - If N==0 or N>DEPTH: next state ERROR, load_error=1 the next cycle, no bytes accepted.
  - Otherwise: next state LOAD.
  - load_start has priority over a same-cycle transfer; that byte is not accepted.
  - load_start during LOAD or CHECK aborts and restarts the load.
- LOAD: load_ready=1, cpu_hold=1.
  - Each transfer: mem[wr_ptr]<=load_data; sum+=load_data; wr_ptr++.
  - The transfer that writes index N-1 moves the state to CHECK.
  - Words at index >= N remain 0.
- CHECK: load_ready=1, cpu_hold=1. One transfer only; that byte is added to the sum, not stored.
  - Sum==0: go to RUN; load_done pulses high for 1 cycle, in the cycle after the checksum transfer.
  - Sum!=0: go to ERROR.
- RUN: load_ready=0, cpu_hold=0. The processor fetches from address 0. Stays in RUN until load_start or rst.
- ERROR: load_ready=0, cpu_hold=1, load_error=1. Memory keeps its partial contents. Leaves only on load_start or rst.
- cpu_hold and load_ready are registered (state-decoded) and change in the cycle after the state transition.
- Idle inputs: load_valid while load_ready=0 is ignored. A stalled stream (load_valid low) waits indefinitely with no timeout.
- Wrap-around: N==DEPTH fills every word; wr_ptr does not wrap into address 0 because the state leaves LOAD at index DEPTH-1.

Test Plan:
- Reset → state: assert rst mid-load after 2 of 4 bytes → cpu_hold=1, load_ready=0, instruction_data=0x00 at every address, load_error=0.
- Good 3-byte load: load_start, N=3; bytes 0x12,0x34,0x56; checksum 0x64 (0x12+0x34+0x56=0x9C, 0x9C+0x64=0x100) → load_done pulses once; cpu_hold falls 1 cycle after the state enters RUN. ProgramAddress 0,1,2,3 reads 0x12,0x34,0x56,0x00.
- Bad checksum: same bytes with checksum 0x65 → load_error=1, cpu_hold stays 1, no load_done. A new load_start clears load_error the next cycle.
- Back-pressure and gaps: N=16, load_valid toggled randomly, sum made 0 → all 16 words correct, exactly 17 transfers, no lost or duplicated byte.
- Illegal length: N=0, and separately N=17 → ERROR within 1 cycle; load_ready never asserts; memory reads all 0x00.
- Restart mid-load: after 2 of 5 bytes, pulse load_start with N=1 in the same cycle as load_valid=1 → that byte is not written. Stream 0xA5 then 0x5B → RUN; mem[0]=0xA5, mem[1..15]=0x00.

Source files
------------

// File: rtl/k2_program_loader.sv
// Writable K2 instruction store: loads a program over a byte stream, verifies a
// trailing checksum, and holds the processor in reset until a good image is resident.
`timescale 1ns/1ps
module k2_program_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned INST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] ProgramAddress,
  output logic [INST_W-1:0] instruction_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;

  state_t            state, next_state;
  logic [INST_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [INST_W-1:0] sum, sum_next;
  logic [ADDR_W:0]   len;
  logic              len_ok, xfer, last_word, sum_good;

  assign instruction_data = mem[ProgramAddress];

  always_comb begin
    len_ok     = (load_len != '0) && (load_len <= DEPTH_L);
    // load_start wins over a same-cycle byte, so that byte is never consumed
    xfer       = load_valid && load_ready && !load_start &&
                 ((state == LOAD) || (state == CHECK));
    sum_next   = sum + load_data;
    sum_good   = (sum_next == '0);
    last_word  = ({1'b0, wr_ptr} == (len - 1'b1));
    next_state = state;
    if (load_start) begin
      next_state = len_ok ? LOAD : ERROR;
    end else begin
      case (state)
        LOAD:    if (xfer && last_word) next_state = CHECK;
        CHECK:   if (xfer) next_state = sum_good ? RUN : ERROR;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      sum        <= '0;
      len        <= '0;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= next_state;
      // status outputs decode the current state, so they trail a transition by one cycle
      load_ready <= (state == LOAD) || (state == CHECK);
      cpu_hold   <= (state != RUN);
      load_done  <= (state == CHECK) && xfer && sum_good;
      load_error <= (next_state == ERROR);
      if (load_start) begin
        wr_ptr <= '0;
        sum    <= '0;
        len    <= load_len;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (xfer) begin
        sum <= sum_next;
        if (state == LOAD) begin
          mem[wr_ptr] <= load_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_k2_program_loader.sv
// Scoreboard bench for k2_program_loader: stimulus queues expectations, a
// negedge monitor compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_k2_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [4:0] load_len;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] ProgramAddress;
  logic [7:0] instruction_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  k2_program_loader #(.ADDR_W(4), .INST_W(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .ProgramAddress(ProgramAddress), .instruction_data(instruction_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef enum int {K_HOLD, K_READY, K_ERR, K_DONE, K_RD, K_DCNT, K_XCNT} kind_t;
  typedef struct {
    string name;
    kind_t kind;
    int    exp;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: counts pulses/transfers, then drains every pending expectation.
  always @(negedge clk) begin
    chk_t e;
    int   act;
    if (load_done) done_cnt++;
    if (load_valid && load_ready && !load_start && !rst) xfer_cnt++;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_HOLD:  act = int'(cpu_hold);
        K_READY: act = int'(load_ready);
        K_ERR:   act = int'(load_error);
        K_DONE:  act = int'(load_done);
        K_RD:    act = int'(instruction_data);
        K_DCNT:  act = done_cnt;
        default: act = xfer_cnt;
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic push(input kind_t k, input int exp, input string name);
    chk_t e;
    e.kind = k;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] n);
    next_cycle();
    load_start = 1'b1;
    load_len   = n;
    next_cycle();
    load_start = 1'b0;
  endtask

  // Offer one byte until it is accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] b, input bit gaps);
    int  tries;
    bit  sent;
    tries     = 0;
    sent      = 1'b0;
    load_data = b;
    while (!sent && tries < 64) begin
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (load_valid && load_ready) sent = 1'b1;
      next_cycle();
      tries++;
    end
    load_valid = 1'b0;
    if (!sent) begin
      push(K_READY, 1, "send_timeout_ready");
      settle();
    end
  endtask

  task automatic read_all(input logic [7:0] exp [16], input string tag);
    for (int i = 0; i < 16; i++) begin
      ProgramAddress = 4'(i);
      push(K_RD, int'(exp[i]), $sformatf("%s[%0d]", tag, i));
      settle();
    end
  endtask

  logic [7:0] zeros [16];
  logic [7:0] img_good [16];
  logic [7:0] img_seq [16];
  logic [7:0] img_one [16];
  int         base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      zeros[i]    = 8'h00;
      img_good[i] = 8'h00;
      img_one[i]  = 8'h00;
      img_seq[i]  = 8'(i * 17);
    end
    img_good[0] = 8'h12; img_good[1] = 8'h34; img_good[2] = 8'h56;
    img_one[0]  = 8'hA5;

    rst = 1'b1; load_start = 1'b0; load_len = '0; load_data = '0;
    load_valid = 1'b0; ProgramAddress = '0;
    next_cycle();
    push(K_HOLD, 1, "por_hold"); push(K_READY, 0, "por_ready");
    push(K_ERR, 0, "por_error"); push(K_DONE, 0, "por_done");
    settle();
    next_cycle();
    rst = 1'b0;

    // Reset in the middle of a 4-byte load
    start(5'd4);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    ProgramAddress = 4'd1;
    push(K_RD, 8'h22, "partial_word1");
    push(K_READY, 1, "midload_ready");
    settle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    push(K_HOLD, 1, "rst_hold"); push(K_READY, 0, "rst_ready");
    push(K_ERR, 0, "rst_error");
    settle();
    read_all(zeros, "rst_mem");

    // Good 3-instruction image
    start(5'd3);
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h64, 1'b0);
    push(K_DONE, 1, "good_done"); push(K_HOLD, 1, "good_hold_lag");
    push(K_ERR, 0, "good_error");
    settle();
    next_cycle();
    push(K_DONE, 0, "good_done_fall"); push(K_HOLD, 0, "good_hold_fall");
    push(K_READY, 0, "good_ready"); push(K_DCNT, 1, "good_done_count");
    settle();
    read_all(img_good, "good_mem");

    // Bad checksum
    start(5'd3);
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h65, 1'b0);
    push(K_ERR, 1, "bad_error"); push(K_DONE, 0, "bad_done");
    settle();
    next_cycle();
    push(K_HOLD, 1, "bad_hold"); push(K_READY, 0, "bad_ready");
    push(K_ERR, 1, "bad_error_level"); push(K_DCNT, 1, "bad_done_count");
    settle();
    read_all(img_good, "bad_mem");
    start(5'd3);
    push(K_ERR, 0, "restart_clears_error"); push(K_HOLD, 1, "restart_hold");
    settle();

    // Full 16-word image with random gaps: 0x00,0x11..0xFF sums to 0xF8, checksum 0x08
    base = xfer_cnt;
    start(5'd16);
    for (int i = 0; i < 16; i++) send(img_seq[i], 1'b1);
    send(8'h08, 1'b1);
    push(K_DONE, 1, "bp_done");
    settle();
    next_cycle();
    push(K_HOLD, 0, "bp_hold"); push(K_DCNT, 2, "bp_done_count");
    push(K_XCNT, base + 17, "bp_transfers");
    settle();
    read_all(img_seq, "bp_mem");

    // Illegal lengths 0 and 17
    for (int t = 0; t < 2; t++) begin
      start(t == 0 ? 5'd0 : 5'd17);
      push(K_ERR, 1, $sformatf("illegal%0d_error", t));
      push(K_READY, 0, $sformatf("illegal%0d_ready", t));
      settle();
      load_data  = 8'hEE;
      load_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        next_cycle();
        push(K_READY, 0, $sformatf("illegal%0d_ready_c%0d", t, c));
        push(K_HOLD, 1, $sformatf("illegal%0d_hold_c%0d", t, c));
      end
      settle();
      load_valid = 1'b0;
      push(K_XCNT, base + 17, $sformatf("illegal%0d_no_transfer", t));
      settle();
      read_all(zeros, $sformatf("illegal%0d_mem", t));
    end

    // Restart mid-load with a same-cycle byte that must be dropped
    start(5'd5);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    load_start = 1'b1;
    load_len   = 5'd1;
    load_data  = 8'h77;
    load_valid = 1'b1;
    next_cycle();
    load_start = 1'b0;
    load_valid = 1'b0;
    send(8'hA5, 1'b0);
    send(8'h5B, 1'b0);
    push(K_DONE, 1, "restart_done");
    settle();
    next_cycle();
    push(K_HOLD, 0, "restart_run_hold"); push(K_DCNT, 3, "restart_done_count");
    push(K_ERR, 0, "restart_run_error");
    settle();
    read_all(img_one, "restart_mem");

    settle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
